// File: rtl/axil_pkg.sv
// Shared types for the AXI-Lite command master: response codes and FSM states.
package axil_pkg;

   // AXI-Lite response codes
   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } axil_resp_t;

   // Master transaction FSM states
   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      WR_ADDR_DATA = 3'd1,
      WR_RESP      = 3'd2,
      RD_ADDR      = 3'd3,
      RD_DATA      = 3'd4,
      RESP         = 3'd5
   } axil_master_state_t;

   // Error responses are the ones with the high code bit set
   function automatic logic resp_is_err(input axil_resp_t r);
      return (r == SLVERR) || (r == DECERR);
   endfunction

endpackage

// File: rtl/axil_master_if.sv
// AXI-Lite bus bundle with initiator (master) and responder (slave) views.
interface axil_master_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid,    input wready,
      input  bresp, bvalid,           output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid,    output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid,    output wready,
      output bresp, bvalid,           input bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid,    input rready
   );
endinterface

// File: rtl/axil_watchdog.sv
// Response watchdog for axil_master (only built with AXIL_MASTER_TIMEOUT_EN).
// Counts cycles while enabled; expired is high in the LIMIT-th enabled cycle.
module axil_watchdog #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired_c
);
   localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] r_count;

   // Count enabled cycles, saturating at the limit
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != LAST)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_expired_c = i_enable && (r_count == LAST);

endmodule

// File: rtl/axil_master.sv
// Single-outstanding AXI-Lite initiator: accepts a read/write command,
// runs it on the AXI-Lite channels and returns data plus an error flag.
// Optional macro AXIL_MASTER_TIMEOUT_EN adds a response watchdog and keeps
// bready/rready high in IDLE so late beats are absorbed.
module axil_master
   import axil_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_write,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   input  logic [STRB_WIDTH-1:0] i_req_wstrb,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic                  o_rsp_err,
   axil_master_if.master         m_axil
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("axil_master: TIMEOUT_CYCLES must be at least 1");
   end

   axil_master_state_t    r_state;
   logic                  r_req_ready;
   logic                  r_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [STRB_WIDTH-1:0] r_wstrb;
   logic                  r_awvalid;
   logic                  r_wvalid;
   logic                  r_bready;
   logic                  r_arvalid;
   logic                  r_rready;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;

   logic                  w_beat;
   logic [1:0]            w_beat_resp;
   logic [DATA_WIDTH-1:0] w_beat_data;
   logic                  w_wd_expired;

`ifdef AXIL_MASTER_TIMEOUT_EN
   localparam logic IDLE_READY = 1'b1;

   logic w_wd_active;

   // Watchdog runs only while waiting for a B or R beat
   assign w_wd_active = (r_state == WR_RESP) || (r_state == RD_DATA);

   axil_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk         (clk),
      .rst         (rst),
      .i_clear     (!w_wd_active),
      .i_enable    (w_wd_active),
      .o_expired_c (w_wd_expired)
   );
`else
   localparam logic IDLE_READY = 1'b0;

   assign w_wd_expired = 1'b0;
`endif

   // Response beat of the channel matching the latched direction
   assign w_beat      = r_write ? m_axil.bvalid : m_axil.rvalid;
   assign w_beat_resp = r_write ? m_axil.bresp  : m_axil.rresp;
   assign w_beat_data = r_write ? '0 : m_axil.rdata;

   // Transaction FSM with registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_req_ready <= 1'b1;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_bready <= IDLE_READY;
               r_rready <= IDLE_READY;
               if (i_req_valid && r_req_ready) begin
                  r_req_ready <= 1'b0;
                  r_write     <= i_req_write;
                  r_addr      <= i_req_addr;
                  r_wdata     <= i_req_wdata;
                  r_wstrb     <= i_req_wstrb;
                  r_bready    <= 1'b0;
                  r_rready    <= 1'b0;
                  if (i_req_write) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= WR_ADDR_DATA;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= RD_ADDR;
                  end
               end
            end

            WR_ADDR_DATA: begin
               if (m_axil.awready) r_awvalid <= 1'b0;
               if (m_axil.wready)  r_wvalid  <= 1'b0;
               if ((!r_awvalid || m_axil.awready) && (!r_wvalid || m_axil.wready)) begin
                  r_bready <= 1'b1;
                  r_state  <= WR_RESP;
               end
            end

            RD_ADDR: begin
               if (m_axil.arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= RD_DATA;
               end
            end

            WR_RESP, RD_DATA: begin
               if (w_beat || w_wd_expired) begin
                  r_bready    <= 1'b0;
                  r_rready    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
                  if (w_beat) begin
                     r_rsp_rdata <= w_beat_data;
                     r_rsp_err   <= resp_is_err(axil_resp_t'(w_beat_resp));
                  end else begin
                     r_rsp_rdata <= '0;
                     r_rsp_err   <= 1'b1;
                  end
               end
            end

            RESP: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_bready    <= IDLE_READY;
                  r_rready    <= IDLE_READY;
                  r_state     <= IDLE;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_req_ready    = r_req_ready;
   assign o_rsp_valid    = r_rsp_valid;
   assign o_rsp_rdata    = r_rsp_rdata;
   assign o_rsp_err      = r_rsp_err;

   assign m_axil.awaddr  = r_addr;
   assign m_axil.awprot  = 3'b000;
   assign m_axil.awvalid = r_awvalid;
   assign m_axil.wdata   = r_wdata;
   assign m_axil.wstrb   = r_wstrb;
   assign m_axil.wvalid  = r_wvalid;
   assign m_axil.bready  = r_bready;
   assign m_axil.araddr  = r_addr;
   assign m_axil.arprot  = 3'b000;
   assign m_axil.arvalid = r_arvalid;
   assign m_axil.rready  = r_rready;

endmodule

// File: tb/tb_axil_master.sv
// Self-checking bench for axil_master: directed and random transactions
// against a cycle-level responder and a transaction-level expectation model.
module tb_axil_master;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;
`ifdef AXIL_MASTER_TIMEOUT_EN
   localparam int TO   = 4;
   localparam int BMAX = 2;
`else
   localparam int TO   = 255;
   localparam int BMAX = 3;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req_valid;
   logic          o_req_ready;
   logic          i_req_write;
   logic [AW-1:0] i_req_addr;
   logic [DW-1:0] i_req_wdata;
   logic [SW-1:0] i_req_wstrb;
   logic          o_rsp_valid;
   logic          i_rsp_ready;
   logic [DW-1:0] o_rsp_rdata;
   logic          o_rsp_err;

   int n_vec = 0;
   int n_err = 0;

   axil_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

   axil_master #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_write (i_req_write),
      .i_req_addr  (i_req_addr),
      .i_req_wdata (i_req_wdata),
      .i_req_wstrb (i_req_wstrb),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_rdata (o_rsp_rdata),
      .o_rsp_err   (o_rsp_err),
      .m_axil      (axi)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic slave_idle();
      axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
      axi.bvalid  = 1'b0; axi.bresp  = 2'b00;
      axi.rvalid  = 1'b0; axi.rresp  = 2'b00; axi.rdata = '0;
   endtask

   // One command through the DUT. d_a/d_w: cycles the address/write channel
   // waits for ready; d_b: cycles before the B/R beat (-1 = never);
   // d_rsp: cycles rsp_ready is held low.
   task automatic run_txn(input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [SW-1:0] strb,
                          input int d_a, input int d_w, input int d_b,
                          input logic [1:0] resp, input logic [DW-1:0] rdat,
                          input int d_rsp);
      int k, n, a_hi, w_hi, a_wait, w_wait, b_wait, hold, rsp_k, rsp_hi, exp_lat, mx;
      logic a_done, w_done, b_act, b_pend, b_done, rsp_seen, fin, rdy;
      logic bad_pay, bad_rsp, bad_other, exp_err;
      logic [DW-1:0] exp_data;
      string pfx;

      pfx = wr ? "wr" : "rd";
      a_hi = 0; w_hi = 0; a_wait = 0; w_wait = 0; b_wait = 0; hold = 0;
      rsp_k = 0; rsp_hi = 0;
      a_done = 1'b0; w_done = !wr; b_act = 1'b0; b_pend = 1'b0; b_done = 1'b0;
      rsp_seen = 1'b0; fin = 1'b0; bad_pay = 1'b0; bad_rsp = 1'b0; bad_other = 1'b0;
      mx = wr ? ((d_a > d_w) ? d_a : d_w) : d_a;
      if (d_b < 0) begin
         exp_data = '0;
         exp_err  = 1'b1;
         exp_lat  = mx + 2 + TO;
      end else begin
         exp_data = wr ? '0 : rdat;
         exp_err  = resp[1];
         exp_lat  = mx + 3 + d_b;
      end

      @(negedge clk);
      slave_idle();
      i_req_valid = 1'b1; i_req_write = wr; i_req_addr = addr;
      i_req_wdata = data; i_req_wstrb = strb;
      n = 0;
      while (!o_req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({pfx, "_req_ready"}, 64'(o_req_ready), 64'(1));
      @(negedge clk);
      i_req_valid = 1'b0;
      k = 1;

      while (!fin && k < 400) begin
         if (rsp_seen && !o_rsp_valid) begin
            fin = 1'b1;
            i_rsp_ready = 1'b0;
         end else begin
            // B or R beat
            if (b_pend) begin
               axi.bvalid = 1'b0; axi.rvalid = 1'b0;
               b_act = 1'b0; b_pend = 1'b0; b_done = 1'b1;
            end
            if (a_done && w_done && !b_act && !b_done && d_b >= 0) begin
               if (b_wait == d_b) begin
                  b_act = 1'b1;
                  if (wr) begin
                     axi.bvalid = 1'b1; axi.bresp = resp;
                  end else begin
                     axi.rvalid = 1'b1; axi.rresp = resp; axi.rdata = rdat;
                  end
               end else begin
                  b_wait++;
               end
            end
            if (b_act && (wr ? axi.bready : axi.rready)) b_pend = 1'b1;

            // AW or AR
            rdy = 1'b0;
            if (wr ? axi.awvalid : axi.arvalid) begin
               a_hi++;
               if (wr) bad_pay |= (axi.awaddr != addr) || (axi.awprot != 3'b000);
               else    bad_pay |= (axi.araddr != addr) || (axi.arprot != 3'b000);
               if (a_wait == d_a) begin
                  rdy = 1'b1; a_done = 1'b1;
               end else begin
                  a_wait++;
               end
            end
            axi.awready = wr & rdy;
            axi.arready = !wr & rdy;

            // W
            if (wr && axi.wvalid) begin
               w_hi++;
               bad_pay |= (axi.wdata != data) || (axi.wstrb != strb);
               if (w_wait == d_w) begin
                  axi.wready = 1'b1; w_done = 1'b1;
               end else begin
                  axi.wready = 1'b0; w_wait++;
               end
            end else begin
               axi.wready = 1'b0;
            end

            bad_other |= wr ? (axi.arvalid | axi.rready)
                            : (axi.awvalid | axi.wvalid | axi.bready);

            // Command response
            if (o_rsp_valid) begin
               if (!rsp_seen) begin
                  rsp_seen = 1'b1;
                  rsp_k = k;
                  chk({pfx, "_rsp_rdata"}, 64'(o_rsp_rdata), 64'(exp_data));
                  chk({pfx, "_rsp_err"}, 64'(o_rsp_err), 64'(exp_err));
               end
               rsp_hi++;
               bad_rsp |= (o_rsp_rdata != exp_data) || (o_rsp_err != exp_err) || o_req_ready;
               if (hold == d_rsp) begin
                  i_rsp_ready = 1'b1;
               end else begin
                  i_rsp_ready = 1'b0; hold++;
               end
            end
            @(negedge clk);
            k++;
         end
      end
      i_rsp_ready = 1'b0;
      slave_idle();

      chk({pfx, "_completed"}, 64'(fin), 64'(1));
      chk({pfx, "_latency"}, 64'(rsp_k), 64'(exp_lat));
      chk({pfx, "_rsp_cycles"}, 64'(rsp_hi), 64'(d_rsp + 1));
      chk({pfx, "_addr_valid_cycles"}, 64'(a_hi), 64'(d_a + 1));
      if (wr) chk("wr_wvalid_cycles", 64'(w_hi), 64'(d_w + 1));
      chk({pfx, "_resp_beat_taken"}, 64'(b_done), 64'(d_b >= 0));
      chk({pfx, "_payload_stable"}, 64'(bad_pay), 64'(0));
      chk({pfx, "_rsp_stable"}, 64'(bad_rsp), 64'(0));
      chk({pfx, "_other_chan_quiet"}, 64'(bad_other), 64'(0));
   endtask

   initial begin
      #1ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time bound exceeded");
   end

   initial begin
      int n;
      logic saw;
      rst = 1'b1;
      i_req_valid = 1'b0; i_req_write = 1'b0; i_req_addr = '0;
      i_req_wdata = '0; i_req_wstrb = '0; i_rsp_ready = 1'b0;
      slave_idle();
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_req_ready", 64'(o_req_ready), 64'(1));
      chk("rst_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready,
                             axi.rready, o_rsp_valid, o_rsp_err}), 64'(0));
      chk("rst_latched", 64'({axi.awaddr, axi.wdata, axi.wstrb}), 64'(0));
      chk("rst_rsp_rdata", 64'(o_rsp_rdata), 64'(0));
      rst = 1'b0;

      // Directed cases
      run_txn(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, '0, 0);
      run_txn(1'b1, 16'h0020, 32'hA5A5_0F0F, 4'h3, 3, 0, 0, 2'b00, '0, 0);
      run_txn(1'b1, 16'h0024, 32'h0000_1111, 4'h8, 0, 2, 1, 2'b11, '0, 1);
      run_txn(1'b0, 16'h0008, '0, '0, 0, 0, 0, 2'b10, 32'h12345678, 0);
      run_txn(1'b0, 16'h000C, '0, '0, 1, 0, 2, 2'b01, 32'hCAFE_BABE, 5);

      // Reset while waiting for B
      @(negedge clk);
      i_req_valid = 1'b1; i_req_write = 1'b1; i_req_addr = 16'h00A0;
      i_req_wdata = 32'h7777_8888; i_req_wstrb = 4'hF;
      axi.awready = 1'b1; axi.wready = 1'b1;
      @(negedge clk);
      i_req_valid = 1'b0;
      n = 0;
      while (!axi.bready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_in_wr_resp", 64'({axi.bready, o_req_ready}), 64'(2'b10));
      axi.awready = 1'b0; axi.wready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_req_ready", 64'(o_req_ready), 64'(1));
      chk("rst_mid_valids", 64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready,
                                 axi.rready, o_rsp_valid}), 64'(0));
      chk("rst_mid_latched", 64'({axi.awaddr, axi.wdata}), 64'(0));
      rst = 1'b0;
      saw = 1'b0;
      repeat (8) begin
         @(negedge clk);
         saw |= o_rsp_valid;
      end
      chk("rst_mid_no_rsp", 64'(saw), 64'(0));

`ifdef AXIL_MASTER_TIMEOUT_EN
      // Read whose R beat never comes, then a stale R beat in IDLE
      run_txn(1'b0, 16'h0010, '0, '0, 0, 0, -1, 2'b00, 32'hCAFEF00D, 1);
      @(negedge clk);
      chk("idle_ready_pair", 64'({axi.bready, axi.rready}), 64'(2'b11));
      axi.rvalid = 1'b1; axi.rresp = 2'b10; axi.rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      axi.rvalid = 1'b0;
      chk("late_r_absorbed", 64'({o_rsp_valid, o_req_ready}), 64'(2'b01));
      run_txn(1'b0, 16'h0014, '0, '0, 0, 0, 0, 2'b00, 32'h0BAD_CAFE, 0);
`endif

      // Random traffic
      for (int t = 0; t < 40; t++) begin
         run_txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), SW'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, BMAX)), 2'($urandom), DW'($urandom),
                 int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
